dmg_timer: RTL

The DMG timer peripheral provides DIV, TIMA, TMA and TAC at 0xFF04–0xFF07. It sits on the CPU memory bus beside the memory map and drives `timer_int` toward the interrupt logic. It runs on the CPU clock, with one `clock` cycle equal to one CPU T-cycle. It reproduces DMG falling-edge counter behaviour, including the 4-cycle overflow reload delay and the DIV/TAC write glitches.

---
 rtl/dmg_timer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dmg_timer.sv
// dmg_timer: DMG DIV/TIMA/TMA/TAC timer peripheral at 0xFF04-0xFF07.
// Falling-edge TIMA clocking, delayed overflow reload, DIV/TAC glitches.
module dmg_timer #(
    parameter logic [15:0] DIV_RESET_VALUE = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wren,
    input  logic [7:0]  cpu_data_in,
    output logic [7:0]  cpu_data_out,
    output logic        sel,
    output logic        timer_int
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DELAY  = 2'd1,
        RELOAD = 2'd2
    } state_t;

    localparam logic [15:0] A_DIV  = 16'hFF04;
    localparam logic [15:0] A_TIMA = 16'hFF05;
    localparam logic [15:0] A_TMA  = 16'hFF06;
    localparam logic [15:0] A_TAC  = 16'hFF07;

    logic [15:0] div_q, div_d;
    logic [7:0]  tima_q, tima_d;
    logic [7:0]  tma_q, tma_d;
    logic [2:0]  tac_q, tac_d;
    logic        tick_q, tick;
    logic        tap_bit;
    logic        fall;
    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        int_q, int_d;
    logic        wr_div, wr_tima, wr_tma, wr_tac;

    assign wr_div  = cpu_wren && (cpu_addr == A_DIV);
    assign wr_tima = cpu_wren && (cpu_addr == A_TIMA);
    assign wr_tma  = cpu_wren && (cpu_addr == A_TMA);
    assign wr_tac  = cpu_wren && (cpu_addr == A_TAC);

    // Address decode and combinational read mux
    always_comb begin
        sel = (cpu_addr[15:2] == 14'h3FC1);
        case (cpu_addr)
            A_DIV:   cpu_data_out = div_q[15:8];
            A_TIMA:  cpu_data_out = tima_q;
            A_TMA:   cpu_data_out = tma_q;
            A_TAC:   cpu_data_out = {5'b11111, tac_q};
            default: cpu_data_out = 8'hFF;
        endcase
    end

    // Divider tap selected by TAC[1:0]
    always_comb begin
        unique case (tac_q[1:0])
            2'b00: tap_bit = div_q[9];
            2'b01: tap_bit = div_q[3];
            2'b10: tap_bit = div_q[5];
            2'b11: tap_bit = div_q[7];
        endcase
    end

    assign tick = tac_q[2] & tap_bit;
    assign fall = tick_q & ~tick;

    // Simple register next-state: divider, TMA, TAC
    always_comb begin
        div_d = wr_div ? 16'h0000 : div_q + 16'h0001;
        tma_d = wr_tma ? cpu_data_in : tma_q;
        tac_d = wr_tac ? cpu_data_in[2:0] : tac_q;
    end

    // Overflow FSM next state; DELAY counts 2,1,0 then one RELOAD cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (fall && !wr_tima && (tima_q == 8'hFF)) begin
                    state_d = DELAY;
                    cnt_d   = 2'd2;
                end
            end
            DELAY: begin
                if (wr_tima) begin
                    state_d = RUN;
                end else if (cnt_q == 2'd0) begin
                    state_d = RELOAD;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RELOAD: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Overflow FSM outputs: TIMA update and interrupt pulse
    always_comb begin
        tima_d = tima_q;
        int_d  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (wr_tima) begin
                    tima_d = cpu_data_in;
                end else if (fall) begin
                    tima_d = tima_q + 8'h01;
                end
            end
            DELAY: begin
                tima_d = wr_tima ? cpu_data_in : 8'h00;
            end
            RELOAD: begin
                // TIMA writes lose here; a same-edge TMA write is used
                tima_d = tma_d;
                int_d  = 1'b1;
            end
            default: begin
                tima_d = tima_q;
            end
        endcase
    end

    // State register for all timer state
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q   <= DIV_RESET_VALUE;
            tima_q  <= 8'h00;
            tma_q   <= 8'h00;
            tac_q   <= 3'b000;
            tick_q  <= 1'b0;
            state_q <= RUN;
            cnt_q   <= 2'd0;
            int_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            tima_q  <= tima_d;
            tma_q   <= tma_d;
            tac_q   <= tac_d;
            tick_q  <= tick;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            int_q   <= int_d;
        end
    end

    assign timer_int = int_q;

endmodule
